// File: rtl/manual_step_debouncer.sv
// manual_step_debouncer
//   Cleans up the raw manual-clock push-button. A two-flop synchronizer feeds
//   a four-state debounce FSM. The FSM accepts a new level only after
//   DEBOUNCE_CYCLES consecutive samples of that level. Outputs are a
//   registered level plus one-cycle press and release strobes.
//
//   Optional build macro MANUAL_STEP_REPEAT_EN: while the button stays
//   pressed, extra step_pulse strobes are issued. The first comes after
//   REPEAT_DELAY cycles, and later ones every REPEAT_PERIOD cycles.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   btn_in        raw asynchronous button, 1 = pressed
//   btn_level     debounced level
//   step_pulse    one-cycle strobe per accepted press (and per repeat)
//   release_pulse one-cycle strobe per accepted release
module manual_step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic step_pulse,
  output logic release_pulse
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s1, btn_sync;
  logic             level_nxt, step_nxt, rel_nxt;
  logic             rpt_fire;

  // Two-flop synchronizer; only btn_sync is seen by the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      s1       <= btn_in;
      btn_sync <= s1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = btn_level;
    step_nxt  = 1'b0;
    rel_nxt   = 1'b0;
    case (state)
      IDLE: begin
        level_nxt = 1'b0;
        if (btn_sync) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = ONE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          // Bounce: drop back silently.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_TERM) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          step_nxt  = 1'b1;
        end else if (cnt < DB_TERM) begin
          cnt_nxt = cnt + ONE;
        end
      end
      PRESSED: begin
        level_nxt = 1'b1;
        if (!btn_sync) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = ONE;
        end else begin
          step_nxt = rpt_fire;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          // Release bounce: the level never dropped, so no new press strobe.
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == DB_TERM) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
          rel_nxt   = 1'b1;
        end else if (cnt < DB_TERM) begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      step_pulse    <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      btn_level     <= level_nxt;
      step_pulse    <= step_nxt;
      release_pulse <= rel_nxt;
    end
  end

`ifdef MANUAL_STEP_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_TERM = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_TERM = CNT_W'(REPEAT_PERIOD - 1);

  // rpt_cnt counts the cycles since PRESSED was entered, or since the last
  // repeat pulse. rpt_first selects the initial delay over the period.
  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_first;
  logic [CNT_W-1:0] rpt_lim;

  assign rpt_lim  = rpt_first ? RD_TERM : RP_TERM;
  assign rpt_fire = (state == PRESSED) && btn_sync && (rpt_cnt == rpt_lim);

  always_ff @(posedge clk) begin
    if (rst || state != PRESSED || state_nxt != PRESSED) begin
      // Covers entry into PRESSED and every cycle spent outside it.
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else if (rpt_cnt < rpt_lim) begin
      rpt_cnt <= rpt_cnt + ONE;
    end
  end
`else
  // The repeat parameters only matter in the repeat build. They are still
  // referenced here so that this configuration elaborates cleanly.
  localparam bit RPT_CFG = (REPEAT_DELAY > 0) && (REPEAT_PERIOD > 0);
  assign rpt_fire = 1'b0 & RPT_CFG;
`endif

endmodule
